shift_sequencer: RTL and testbench

Multi-cycle controller that shares one 0–3-bit left-shift-logical (LSL) stage between two requesters. Each requester issues a WIDTH-bit operand and a shift amount of 0 to WIDTH-1. The block arbitrates round-robin between the requesters and applies the amount as repeated steps of at most 3 bits, one step per cycle. It returns the result with the requester ID over a valid/ready output port. It sits between the ALU issue logic and the shift datapath.

---
 rtl/shift_seq_pkg.sv | 21 ++
 rtl/shift_step.sv | 16 +
 rtl/shift_sequencer.sv | 132 +++++++++++++
 tb/tb_shift_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift sequencer: FSM state encoding and
// the per-cycle step-size rule for the 0-3 bit shift stage.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned MAX_STEP = 3;

  // Largest step the shared stage can take this cycle without overshooting.
  function automatic logic [1:0] step_size(input int unsigned rem);
    if (rem > MAX_STEP) begin
      return 2'(MAX_STEP);
    end
    return rem[1:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational left-shift-logical by 0..3, built as a shift-by-1 mux stage
// followed by a shift-by-2 mux stage.
module shift_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_step,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_s1;

  assign w_s1   = i_step[0] ? {i_data[WIDTH-2:0], 1'b0} : i_data;
  assign o_data = i_step[1] ? {w_s1[WIDTH-3:0], 2'b00} : w_s1;

endmodule

// File: rtl/shift_sequencer.sv
// Two-requester round-robin front end for a shared 0-3 bit LSL stage; long
// shift amounts are applied as repeated steps, one per cycle.
//
// state | meaning
// IDLE  | waiting for a request; readies follow the round-robin grant
// SHIFT | applying up to 3 bits of the remaining amount per cycle
// DONE  | result presented on out_*; held until out_ready
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [AMT_W-1:0] r_rem;
  logic             r_id;
  logic             r_last_grant;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [AMT_W-1:0] w_rem_nxt;
  logic             w_id_nxt;
  logic             w_last_nxt;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic [AMT_W-1:0] w_sel_amt;
  logic [1:0]       w_step;
  logic [AMT_W-1:0] w_rem_after;
  logic [WIDTH-1:0] w_shifted;

  assign w_idle = (r_state == IDLE);

  // Contention goes to whichever requester was not served last.
  always_comb begin
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
  end

  assign req0_ready = w_idle && (w_grant == 1'b0);
  assign req1_ready = w_idle && (w_grant == 1'b1);
  assign w_accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign w_sel_data = w_grant ? req1_data : req0_data;
  assign w_sel_amt  = w_grant ? req1_amt : req0_amt;

  assign w_step      = step_size(32'(r_rem));
  assign w_rem_after = r_rem - {{(AMT_W-2){1'b0}}, w_step};

  shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .i_data (r_acc),
    .i_step (w_step),
    .o_data (w_shifted)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last_grant;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_sel_data;
          w_rem_nxt   = w_sel_amt;
          w_id_nxt    = w_grant;
          w_last_nxt  = w_grant;
          w_state_nxt = (w_sel_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        w_acc_nxt = w_shifted;
        w_rem_nxt = w_rem_after;
        if (w_rem_after == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_rem        <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_rem        <= w_rem_nxt;
      r_id         <= w_id_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // Result lines stay at zero outside DONE so intermediate shifts never leak.
  assign out_valid = (r_state == DONE);
  assign out_data  = out_valid ? r_acc : '0;
  assign out_id    = out_valid & r_id;
  assign busy      = ~w_idle;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus randomized bench for shift_sequencer; expected results come
// from (data << amt) truncation and a 1+ceil(amt/3) latency rule.
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready, out_id, busy;
  logic [15:0] out_data;

  int tests = 0;
  int fails = 0;
  bit m_last = 1'b1;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // One uncontended operation; stall = number of DONE cycles with out_ready low.
  task automatic run_op(input bit id, input logic [15:0] data, input logic [3:0] amt,
                        input int stall);
    int          lat;
    logic [15:0] exp;
    exp = data << amt;
    lat = 1 + (int'(amt) + 2) / 3;
    out_ready = (stall == 0);
    req0_valid = (id == 1'b0);
    req1_valid = (id == 1'b1);
    if (id) begin
      req1_data = data; req1_amt = amt;
    end else begin
      req0_data = data; req0_amt = amt;
    end
    #1;
    chk("ready_granted", 32'(id ? req1_ready : req0_ready), 32'd1);
    chk("ready_other", 32'(id ? req0_ready : req1_ready), 32'd0);
    step_clk();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = 16'($urandom); req0_amt = 4'($urandom);
    req1_data = 16'($urandom); req1_amt = 4'($urandom);
    for (int k = 1; k < lat; k++) begin
      chk("early_valid", 32'(out_valid), 32'd0);
      chk("busy_shift", 32'(busy), 32'd1);
      step_clk();
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_data", 32'(out_data), 32'(exp));
    chk("out_id", 32'(out_id), 32'(id));
    chk("busy_done", 32'(busy), 32'd1);
    chk("ready_done", 32'({req0_ready, req1_ready}), 32'd0);
    for (int s = 1; s < stall; s++) begin
      step_clk();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(exp));
      chk("stall_id", 32'(out_id), 32'(id));
      chk("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    out_ready = 1'b1;
    step_clk();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    m_last = id;
  endtask

  initial begin
    logic [15:0] d0, d1, d;
    logic [3:0]  a;
    bit          exp_g;
    bit          id;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
    out_ready = 1'b0;
    step_clk();
    step_clk();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd1);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
    reset = 1'b0;
    step_clk();

    // directed: zero shift, split step, max shift, output stall
    run_op(1'b0, 16'h0003, 4'd0, 0);
    run_op(1'b1, 16'h0003, 4'd7, 0);
    run_op(1'b0, 16'hFFFF, 4'd15, 0);
    run_op(1'b1, 16'hA5C3, 4'd2, 4);

    // contention: both held valid, amt=1, alternating grants
    d0 = 16'($urandom); d1 = 16'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = d0; req1_data = d1; req0_amt = 4'd1; req1_amt = 4'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = ~m_last;
      #1;
      chk("cont_ready0", 32'(req0_ready), 32'(exp_g == 1'b0));
      chk("cont_ready1", 32'(req1_ready), 32'(exp_g == 1'b1));
      step_clk();
      chk("cont_shift_ready", 32'({req0_ready, req1_ready}), 32'd0);
      step_clk();
      chk("cont_valid", 32'(out_valid), 32'd1);
      chk("cont_id", 32'(out_id), 32'(exp_g));
      chk("cont_data", 32'(out_data), 32'(16'((exp_g ? d1 : d0) << 1)));
      step_clk();
      m_last = exp_g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step_clk();

    // reset during second SHIFT cycle of an amt=9 op from requester 0
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h1234; req0_amt = 4'd9;
    step_clk();
    req0_valid = 1'b0;
    step_clk();
    reset = 1'b1;
    step_clk();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    m_last = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("midrst_no_out", 32'(out_valid), 32'd0);
      step_clk();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("postrst_ready0", 32'(req0_ready), 32'd1);
    chk("postrst_ready1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step_clk();

    // randomized single-requester operations
    for (int n = 0; n < 24; n++) begin
      id = 1'($urandom);
      d  = 16'($urandom);
      a  = 4'($urandom);
      run_op(id, d, a, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
